// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator: N pulses of H high / L low cycles on sig_o,
// with every falling edge flagged on fall_o. All outputs are registered.
module pulse_train_gen #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned NP_W  = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] high_cyc_i,
    input  logic [CNT_W-1:0] low_cyc_i,
    input  logic [NP_W-1:0]  n_pulses_i,
    output logic             sig_o,
    output logic             fall_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] high_m1_q, high_m1_d;
    logic [CNT_W-1:0] low_m1_q, low_m1_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [NP_W-1:0]  n_last_q, n_last_d;
    logic [NP_W-1:0]  pulse_q, pulse_d;
    logic             sig_q, sig_d;
    logic             fall_q, fall_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept;
    logic             phase_end;
    logic             last_pulse;

    // A programmed length of 0 behaves like 1; the counter holds length-1.
    function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - CNT_W'(1);
    endfunction

    assign accept     = start_i && !abort_i && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign phase_end  = (phase_q == '0);
    assign last_pulse = (pulse_q == n_last_q);

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            high_m1_q <= '0;
            low_m1_q  <= '0;
            phase_q   <= '0;
            n_last_q  <= '0;
            pulse_q   <= '0;
            sig_q     <= 1'b0;
            fall_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            high_m1_q <= high_m1_d;
            low_m1_q  <= low_m1_d;
            phase_q   <= phase_d;
            n_last_q  <= n_last_d;
            pulse_q   <= pulse_d;
            sig_q     <= sig_d;
            fall_q    <= fall_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d   = state_q;
        high_m1_d = high_m1_q;
        low_m1_d  = low_m1_q;
        phase_d   = phase_q;
        n_last_d  = n_last_q;
        pulse_d   = pulse_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    high_m1_d = len_m1(high_cyc_i);
                    low_m1_d  = len_m1(low_cyc_i);
                    phase_d   = len_m1(high_cyc_i);
                    n_last_d  = n_pulses_i - NP_W'(1);
                    pulse_d   = '0;
                    state_d   = (n_pulses_i != '0) ? S_HIGH : S_DONE;
                end
            end
            S_HIGH: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (phase_end) begin
                    state_d = S_LOW;
                    phase_d = low_m1_q;
                end else begin
                    phase_d = phase_q - CNT_W'(1);
                end
            end
            S_LOW: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (phase_end) begin
                    if (last_pulse) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_HIGH;
                        phase_d = high_m1_q;
                        pulse_d = pulse_q + NP_W'(1);
                    end
                end else begin
                    phase_d = phase_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear in the same cycle as the state.
    always_comb begin
        sig_d  = (state_d == S_HIGH);
        busy_d = (state_d == S_HIGH) || (state_d == S_LOW);
        done_d = (state_d == S_DONE);
        fall_d = sig_q && !sig_d;
    end

    assign sig_o  = sig_q;
    assign fall_o = fall_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

    a_fall_not_high: assert property (@(posedge clk_i) disable iff (!rst_ni) !(fall_o && sig_o));
    a_busy_done_excl: assert property (@(posedge clk_i) disable iff (!rst_ni) !(busy_o && done_o));

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: vector table, hand-written corner sequences, and a
// per-cycle scoreboard plus negative-edge-detector loopback over random trains.
module tb_pulse_train_gen;

    localparam int CNT_W = 10;
    localparam int NP_W  = 8;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b1;
    logic             start_i = 1'b0;
    logic             abort_i = 1'b0;
    logic [CNT_W-1:0] high_cyc_i = '0;
    logic [CNT_W-1:0] low_cyc_i = '0;
    logic [NP_W-1:0]  n_pulses_i = '0;
    logic             sig_o, fall_o, busy_o, done_o;

    int n_checks = 0;
    int n_pass   = 0;
    bit loopback_on = 1'b0;

    pulse_train_gen #(.CNT_W(CNT_W), .NP_W(NP_W)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .high_cyc_i (high_cyc_i),
        .low_cyc_i  (low_cyc_i),
        .n_pulses_i (n_pulses_i),
        .sig_o      (sig_o),
        .fall_o     (fall_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic sig;
        logic fall;
        logic busy;
        logic done;
    } obs_t;

    typedef struct {
        int h;
        int l;
        int n;
        int lat;
        int falls;
        int highs;
    } vec_t;

    obs_t exp_q[$];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Expected per-cycle outputs of one accepted train, starting the cycle after acceptance.
    function automatic void push_train(input int h_in, input int l_in, input int n);
        int h = (h_in == 0) ? 1 : h_in;
        int l = (l_in == 0) ? 1 : l_in;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < h; i++)
                exp_q.push_back(obs_t'{sig: 1'b1, fall: 1'b0, busy: 1'b1, done: 1'b0});
            for (int i = 0; i < l; i++)
                exp_q.push_back(obs_t'{sig: 1'b0, fall: (i == 0), busy: 1'b1, done: 1'b0});
        end
        exp_q.push_back(obs_t'{sig: 1'b0, fall: 1'b0, busy: 1'b0, done: 1'b1});
    endfunction

    // Reference negative-edge detector fed by sig_o.
    logic ne_prev_q;
    logic ne;
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ne_prev_q <= 1'b0;
        else         ne_prev_q <= sig_o;
    end
    assign ne = ne_prev_q & ~sig_o;

    // Scoreboard: compare this cycle, then predict from this cycle's inputs.
    always @(negedge clk_i) begin
        obs_t cur;
        obs_t act;
        act = obs_t'{sig: sig_o, fall: fall_o, busy: busy_o, done: done_o};
        if (!rst_ni) begin
            exp_q.delete();
            check("reset_outputs", int'(act), 0);
        end else begin
            if (exp_q.size() != 0) cur = exp_q.pop_front();
            else                   cur = '0;
            check("scoreboard", int'(act), int'(cur));
            if (loopback_on) check("loopback_ne", int'(fall_o), int'(ne));
            if (abort_i && cur.busy) begin
                exp_q.delete();
                exp_q.push_back(obs_t'{sig: 1'b0, fall: cur.sig, busy: 1'b0, done: 1'b0});
            end else if (start_i && !abort_i && !cur.busy) begin
                push_train(int'(high_cyc_i), int'(low_cyc_i), int'(n_pulses_i));
            end
        end
    end

    task automatic wait_idle(input int budget);
        int c = 0;
        while ((busy_o || done_o) && c < budget) begin
            tick();
            c++;
        end
        check("idle_timeout", int'(c >= budget), 0);
    endtask

    // Start one train from idle and measure it up to and including done_o.
    task automatic run_train(input int h, input int l, input int n,
                             output int lat, output int falls, output int highs);
        high_cyc_i = CNT_W'(h);
        low_cyc_i  = CNT_W'(l);
        n_pulses_i = NP_W'(n);
        start_i    = 1'b1;
        tick();
        start_i = 1'b0;
        lat   = 1;
        falls = 0;
        highs = 0;
        while (!done_o && lat < 5000) begin
            falls += int'(fall_o);
            highs += int'(sig_o);
            tick();
            lat++;
        end
        tick();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

    initial begin
        vec_t vecs[9];
        int   lat, falls, highs;
        logic [5:0] b2b_sig;
        logic [5:0] b2b_done;

        vecs[0] = '{h: 3,    l: 2,    n: 4,   lat: 21,   falls: 4,   highs: 12};
        vecs[1] = '{h: 0,    l: 0,    n: 3,   lat: 7,    falls: 3,   highs: 3};
        vecs[2] = '{h: 1,    l: 1,    n: 0,   lat: 1,    falls: 0,   highs: 0};
        vecs[3] = '{h: 5,    l: 5,    n: 2,   lat: 21,   falls: 2,   highs: 10};
        vecs[4] = '{h: 1,    l: 7,    n: 1,   lat: 9,    falls: 1,   highs: 1};
        vecs[5] = '{h: 4,    l: 0,    n: 2,   lat: 11,   falls: 2,   highs: 8};
        vecs[6] = '{h: 2,    l: 3,    n: 255, lat: 1276, falls: 255, highs: 510};
        vecs[7] = '{h: 1023, l: 1023, n: 1,   lat: 2047, falls: 1,   highs: 1023};
        vecs[8] = '{h: 0,    l: 1023, n: 2,   lat: 2049, falls: 2,   highs: 2};

        #2 rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_sig", int'(sig_o), 0);
        check("rst_busy", int'(busy_o), 0);
        rst_ni = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            run_train(vecs[i].h, vecs[i].l, vecs[i].n, lat, falls, highs);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_falls", i), falls, vecs[i].falls);
            check($sformatf("vec%0d_highs", i), highs, vecs[i].highs);
        end

        // Basic timing of the first pulse edges.
        high_cyc_i = 3; low_cyc_i = 2; n_pulses_i = 4; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("basic_rise", int'(sig_o), 1);
        tick(); tick();
        check("basic_high_end", int'(sig_o), 1);
        tick();
        check("basic_fall_sig", int'(sig_o), 0);
        check("basic_fall", int'(fall_o), 1);
        wait_idle(100);

        // Abort mid-pulse, then an immediate restart.
        high_cyc_i = 5; low_cyc_i = 5; n_pulses_i = 2; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick(); tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("abort_sig", int'(sig_o), 0);
        check("abort_fall", int'(fall_o), 1);
        check("abort_busy", int'(busy_o), 0);
        check("abort_done", int'(done_o), 0);
        high_cyc_i = 2; low_cyc_i = 1; n_pulses_i = 1; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("restart_busy", int'(busy_o), 1);
        check("restart_sig", int'(sig_o), 1);
        wait_idle(100);

        // Abort wins over start while idle.
        start_i = 1'b1; abort_i = 1'b1;
        tick();
        start_i = 1'b0; abort_i = 1'b0;
        check("abort_start_busy", int'(busy_o), 0);
        tick();

        // Start held high: period-3 back-to-back trains.
        high_cyc_i = 1; low_cyc_i = 1; n_pulses_i = 1; start_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            b2b_sig[i]  = sig_o;
            b2b_done[i] = done_o;
        end
        start_i = 1'b0;
        check("b2b_sig", int'(b2b_sig), 6'b001001);
        check("b2b_done", int'(b2b_done), 6'b100100);
        wait_idle(100);

        // Config changes during a train are ignored.
        high_cyc_i = 3; low_cyc_i = 1; n_pulses_i = 1; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        high_cyc_i = 7;
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            highs += int'(sig_o);
            tick();
        end
        check("cfg_hold_highs", highs, 3);

        // Asynchronous reset in the HIGH phase.
        high_cyc_i = 3; low_cyc_i = 2; n_pulses_i = 4; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        #2 rst_ni = 1'b0;
        #1;
        check("async_rst_sig", int'(sig_o), 0);
        check("async_rst_busy", int'(busy_o), 0);
        check("async_rst_done", int'(done_o), 0);
        tick(); tick();
        rst_ni = 1'b1;
        tick();
        run_train(3, 2, 4, lat, falls, highs);
        check("post_rst_latency", lat, 21);
        check("post_rst_falls", falls, 4);

        // Loopback: random trains, start offered whenever the generator is free.
        begin
            int trains = 0;
            int cycles = 0;
            loopback_on = 1'b1;
            while (trains < 1000 && cycles < 80000) begin
                if (!busy_o) begin
                    start_i    = 1'b1;
                    high_cyc_i = CNT_W'($urandom_range(1, 8));
                    low_cyc_i  = CNT_W'($urandom_range(1, 8));
                    n_pulses_i = NP_W'($urandom_range(0, 10));
                    trains++;
                end else begin
                    start_i    = 1'b0;
                    high_cyc_i = CNT_W'($urandom_range(0, 15));
                    low_cyc_i  = CNT_W'($urandom_range(0, 15));
                    n_pulses_i = NP_W'($urandom_range(0, 15));
                end
                tick();
                cycles++;
            end
            start_i = 1'b0;
            check("loopback_trains", int'(trains >= 1000), 1);
            wait_idle(200);
            tick();
            loopback_on = 1'b0;
        end

        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
